rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters and produces both a one-hot grant and a 3-bit encoded grant index.
- It wraps the 8-to-3 priority encoding function with a rotating-priority pointer, a grant-hold state machine and a hold-timeout counter.
- It sits between the requester bank and the shared datapath; downstream logic consumes gnt_idx as a mux select.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit i = requester i, level-sensitive.
- done  input  1  current owner finished; sampled only in GRANT.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- gnt_idx  output  3  binary index of the owner, registered; holds last value when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active; equals OR of gnt.
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- States:
  - IDLE: no owner.
  - GRANT: owner held.
- IDLE -> GRANT when req != 0.
  - Winner = first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8, ascending wrap).
  - gnt/gnt_idx/gnt_valid are registered on that edge: 1-cycle latency from req to grant.
  - hold_cnt <= 1.
- GRANT, release conditions (any one), evaluated each cycle:
  - (a) done=1;
  - (b) req[gnt_idx]=0, i.e. the requester withdrew;
  - (c) hold_cnt == MAX_HOLD. Asserts timeout=1 for that edge's following cycle only; if (a) or (b) also holds the same cycle, timeout is still asserted.
- On release:
  - gnt<=0, gnt_valid<=0, state<=IDLE.
  - ptr<=gnt_idx+1 (3-bit wrap: 7 -> 0).
  - gnt_idx keeps its value.
  - There is always one dead cycle with gnt_valid=0 between consecutive grants; there is no back-to-back handoff.
- GRANT with no release condition: hold_cnt increments, saturating at MAX_HOLD; gnt unchanged; changes on other req bits are ignored.
- done asserted in IDLE: ignored.
- req=0 in IDLE: stay IDLE; ptr unchanged.
- Fairness: a continuously requesting agent is granted within 8 grants.
- Reset asserted mid-GRANT: all outputs clear immediately (asynchronous); ptr returns to 0.
- gnt is always one-hot or zero; gnt_valid=1 implies gnt == (1 << gnt_idx).

Decomposition:
- Shared package arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - N_REQ=8;
  - IDX_W=3.
- Sub-module rr_pick8: purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: pick_idx[2:0], pick_valid.
  - Implementation: rotate req right by ptr, apply a fixed lowest-index priority encoder, add ptr back mod 8.
  - Instantiated once; the FSM, pointer and counter live in rr_arbiter_8.

Test Plan:
- Reset then req=8'b1010_0100, done=0 -> next edge: gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; hold stays while done=0.
- From that grant, pulse done=1 for one cycle with req unchanged -> gnt=0 for 1 cycle, ptr=3; then gnt_idx=5, then after done gnt_idx=7, then after done gnt_idx=2 (wrap).
- req=8'hFF constant, done pulsed one cycle after every grant -> gnt_idx sequence 0,1,2,...,7,0, each separated by one idle cycle; no index repeats within 8 grants.
- Single req[4]=1, done held 0, MAX_HOLD=16 -> gnt held exactly 16 cycles, timeout=1 for one cycle at release, re-grant idx 4 after one idle cycle.
- Granted idx 6; deassert req[6] -> release next edge; ptr=7, timeout=0.
- rst_n driven low asynchronously mid-GRANT (between clock edges) -> gnt=0, gnt_valid=0 without waiting for clk; after release with req=8'h80, first grant is idx 7 (ptr=0 scan).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding
// and the index-to-one-hot helper.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_chk.sv
// Structural invariants of the arbiter outputs: grant one-hot or zero and
// consistent with gnt_valid and gnt_idx.
module rr_arbiter_8_chk
  import arb_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  input logic [N_REQ-1:0] gnt,
  input logic [IDX_W-1:0] gnt_idx,
  input logic             gnt_valid
);

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("FAIL chk_onehot gnt=%b", gnt);

  a_valid_or: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt))
    else $error("FAIL chk_valid gnt_valid=%b gnt=%b", gnt_valid, gnt);

  a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
                                gnt_valid |-> (gnt == idx_to_onehot(gnt_idx)))
    else $error("FAIL chk_idx gnt=%b gnt_idx=%0d", gnt, gnt_idx);

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating-priority pick: the first set request scanning upward
// from ptr with wrap-around.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_valid
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]   enc_s;

  // Rotate so ptr lands at bit 0, encode the lowest set bit, then undo the rotation.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N_REQ-1:0];
    enc_s = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      enc_s = rot_s[i] ? i[IDX_W-1:0] : enc_s;
    end
    pick_idx   = enc_s + ptr;
    pick_valid = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with grant hold, release on done or
// withdrawal, and forced release after MAX_HOLD cycles.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [IDX_W-1:0] gnt_idx_r, gnt_idx_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic             timeout_r, timeout_s;

  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             hold_hit_s;
  logic             release_s;

  rr_pick8 u_pick (
    .req        (req),
    .ptr        (ptr_r),
    .pick_idx   (pick_idx_s),
    .pick_valid (pick_valid_s)
  );

  // Release qualifiers for the current owner; timeout wins reporting even if done/withdraw coincide.
  always_comb begin
    hold_hit_s = (hold_cnt_r == HOLD_MAX);
    release_s  = done | ~req[gnt_idx_r] | hold_hit_s;
  end

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s     = ST_GRANT;
          gnt_s       = idx_to_onehot(pick_idx_s);
          gnt_idx_s   = pick_idx_s;
          gnt_valid_s = 1'b1;
          hold_cnt_s  = HOLD_ONE;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_s     = ST_IDLE;
          gnt_s       = {N_REQ{1'b0}};
          gnt_valid_s = 1'b0;
          ptr_s       = gnt_idx_r + 3'd1;
          hold_cnt_s  = {CNT_W{1'b0}};
          timeout_s   = hold_hit_s;
        end else if (hold_cnt_r != HOLD_MAX) begin
          hold_cnt_s  = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_s  = hold_cnt_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = {N_REQ{1'b0}};
        gnt_valid_s = 1'b0;
        hold_cnt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      hold_cnt_r  <= {CNT_W{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_arbiter_8_chk chk (
    .clk(clk), .rst_n(rst_n), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: owner is -1 when nobody holds the resource.
  int m_owner, m_ptr, m_hold, m_idx, m_to;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_idx = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
        end
      end
      if (m_owner >= 0) begin
        m_idx  = m_owner;
        m_hold = 1;
      end
    end else if (d || !r[m_owner] || m_hold == MAX_HOLD) begin
      m_to    = (m_hold == MAX_HOLD) ? 1 : 0;
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_gnt"},       int'(gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
    check({tag, "_gnt_valid"}, int'(gnt_valid), (m_owner < 0) ? 0 : 1);
    check({tag, "_gnt_idx"},   int'(gnt_idx),   m_idx);
    check({tag, "_timeout"},   int'(timeout),   m_to);
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    #12;
    check("rst_gnt",       int'(gnt),       0);
    check("rst_gnt_valid", int'(gnt_valid), 0);
    check("rst_gnt_idx",   int'(gnt_idx),   0);
    check("rst_timeout",   int'(timeout),   0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       vld;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] seen;
    logic [7:0] r;
    logic       d;

    tbl[0] = '{8'hA4, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[1] = '{8'hA4, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[2] = '{8'hA4, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[3] = '{8'hA4, 1'b0, 1'b1, 3'd5, 1'b0};
    tbl[4] = '{8'hA4, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[5] = '{8'hA4, 1'b0, 1'b1, 3'd7, 1'b0};
    tbl[6] = '{8'hA4, 1'b1, 1'b0, 3'd7, 1'b0};
    tbl[7] = '{8'hA4, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[8] = '{8'hA4, 1'b1, 1'b0, 3'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].done, "tbl");
      check("tbl_vld", int'(gnt_valid), int'(tbl[i].vld));
      check("tbl_idx", int'(gnt_idx),   int'(tbl[i].idx));
      check("tbl_to",  int'(timeout),   int'(tbl[i].to));
      check("tbl_gnt", int'(gnt),       tbl[i].vld ? (1 << tbl[i].idx) : 0);
    end

    // All requesting: strict rotation with an idle cycle between grants.
    do_reset();
    seen = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 1'b0, "rr");
      check("rr_idx", int'(gnt_idx), k);
      check("rr_no_repeat", int'(seen[gnt_idx]), 0);
      seen[gnt_idx] = 1'b1;
      step(8'hFF, 1'b1, "rr");
      check("rr_dead_cycle", int'(gnt_valid), 0);
    end
    step(8'hFF, 1'b0, "rr");
    check("rr_wrap_idx", int'(gnt_idx), 0);

    // Lone requester holds until MAX_HOLD forces release.
    do_reset();
    for (int k = 0; k < MAX_HOLD; k++) begin
      step(8'h10, 1'b0, "hold");
      check("hold_valid", int'(gnt_valid), 1);
    end
    step(8'h10, 1'b0, "hold");
    check("hold_release", int'(gnt_valid), 0);
    check("hold_timeout", int'(timeout), 1);
    step(8'h10, 1'b0, "hold");
    check("hold_regrant_idx", int'(gnt_idx), 4);
    check("hold_timeout_pulse", int'(timeout), 0);

    // Withdrawal releases without timeout; ptr moves to 7.
    do_reset();
    step(8'h40, 1'b0, "wd");
    check("wd_idx", int'(gnt_idx), 6);
    step(8'h00, 1'b0, "wd");
    check("wd_release", int'(gnt_valid), 0);
    check("wd_timeout", int'(timeout), 0);
    step(8'hC1, 1'b0, "wd");
    check("wd_ptr7_idx", int'(gnt_idx), 7);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(8'h01, 1'b0, "ar");
    step(8'h01, 1'b0, "ar");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt",       int'(gnt),       0);
    check("ar_gnt_valid", int'(gnt_valid), 0);
    check("ar_gnt_idx",   int'(gnt_idx),   0);
    model_reset();
    #3;
    rst_n = 1'b1;
    step(8'h80, 1'b0, "ar");
    check("ar_first_idx", int'(gnt_idx), 7);

    // Randomized traffic against the model.
    do_reset();
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7, 0) == 0) begin
        if ($urandom_range(1, 0) == 0) r = 8'($urandom);
        else                           r = 8'h01 << $urandom_range(7, 0);
      end
      d = ($urandom_range(9, 0) == 0);
      step(r, d, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
